pulse_seq_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pair of pulse lines (x, y) between NREQ requesters. Each granted requester gets one complete pulse sequence: an x pulse, a programmed number of y pulses, and a closing x pulse. The block drives the x/y inputs of the downstream two-pulse pattern detector. It guarantees that sequences from different requesters never interleave on the shared lines.

---
 rtl/pulse_seq_arbiter.sv | 77 +++++++
 tb/tb_pulse_seq_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_arbiter.sv
// pulse_seq_arbiter: round-robin arbiter sharing one x/y pulse pair among NREQ requesters
// Ports: clk, reset_n (async, active-low); req_i level requests; ycnt_i per-requester
// y counts; abort_i cancels a running sequence; gnt_o one-hot grant; done_o one-hot
// completion pulse; x_o/y_o shared pulse lines; busy_o high outside IDLE.
module pulse_seq_arbiter #(
  parameter int NREQ = 4,
  parameter int CW = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*CW-1:0]   ycnt_i,
  input  logic                 abort_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 x_o,
  output logic                 y_o,
  output logic                 busy_o
);
  localparam int PW = $clog2(NREQ);
  localparam logic [2:0] S_IDLE = 3'd0, S_X1 = 3'd1, S_Y = 3'd2, S_X2 = 3'd3, S_DONE = 3'd4;
  logic [2:0]      state;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   ptr, widx, win_idx, idx, nxt_ptr;
  logic [CW-1:0]   cnt, wcnt;
  logic            found, stop;
  // search upward from ptr with wrap; first hit wins
  always_comb begin
    found = 1'b0;
    win_idx = '0;
    idx = '0;
    wcnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_idx = idx;
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (PW'(i) == win_idx) wcnt = ycnt_i[i*CW +: CW];
  end
  assign nxt_ptr = (widx == PW'(NREQ - 1)) ? '0 : widx + 1'b1;
  assign stop = abort_i && (state == S_X1 || state == S_Y || state == S_X2);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      gnt <= '0;
      ptr <= '0;
      widx <= '0;
      cnt <= '0;
    end else if (stop || state == S_DONE) begin
      state <= S_IDLE;
      gnt <= '0;
      ptr <= nxt_ptr;
    end else if (state == S_IDLE) begin
      if (found) begin
        state <= S_X1;
        gnt <= NREQ'(1) << win_idx;
        widx <= win_idx;
        cnt <= wcnt;
      end
    end else if (state == S_X1) begin
      state <= (cnt != '0) ? S_Y : S_X2;
    end else if (state == S_Y) begin
      cnt <= cnt - 1'b1;
      state <= (cnt == CW'(1)) ? S_X2 : S_Y;
    end else begin
      state <= S_DONE;
    end
  end
  assign busy_o = state != S_IDLE;
  assign x_o = state == S_X1 || state == S_X2;
  assign y_o = state == S_Y;
  assign gnt_o = busy_o ? gnt : '0;
  assign done_o = (state == S_DONE) ? gnt : '0;
endmodule

// File: tb/tb_pulse_seq_arbiter.sv
// tb_pulse_seq_arbiter: directed self-checking bench for pulse_seq_arbiter
module tb_pulse_seq_arbiter;
  logic       clk, reset_n, abort_i, x_o, y_o, busy_o;
  logic [3:0] req_i, gnt_o, done_o;
  logic [7:0] ycnt_i;
  logic [10:0] got, exp;
  int n_chk, n_fail;

  pulse_seq_arbiter #(.NREQ(4), .CW(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .ycnt_i(ycnt_i), .abort_i(abort_i),
    .gnt_o(gnt_o), .done_o(done_o), .x_o(x_o), .y_o(y_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // observed vector: {gnt, done, x, y, busy}
  assign got = {gnt_o, done_o, x_o, y_o, busy_o};

  task automatic do_reset();
    reset_n = 0;
    req_i = '0;
    ycnt_i = '0;
    abort_i = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    #1;
    n_chk++;
    if (got !== 11'b0) begin n_fail++; $display("FAIL reset got %b exp %b", got, 11'b0); end
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_single();
    req_i = 4'b0001;
    ycnt_i = 8'b00000010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp = {(c <= 5) ? 4'b0001 : 4'b0000, (c == 5) ? 4'b0001 : 4'b0000,
             c == 1 || c == 4, c == 2 || c == 3, c <= 5};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL single c%0d got %b exp %b", c, got, exp); end
      if (c == 1) req_i = '0;
    end
  endtask

  task automatic test_zero_count();
    req_i = 4'b0001;
    ycnt_i = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp = {(c <= 3) ? 4'b0001 : 4'b0000, (c == 3) ? 4'b0001 : 4'b0000,
             c == 1 || c == 2, 1'b0, c <= 3};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL zero_count c%0d got %b exp %b", c, got, exp); end
      if (c == 1) req_i = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int p;
    do_reset();
    req_i = 4'b1111;
    ycnt_i = 8'b01010101;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      p = (c - 1) % 5;
      g = 4'b0001 << (((c - 1) / 5) % 4);
      exp = {(p < 4) ? g : 4'b0000, (p == 3) ? g : 4'b0000, p == 0 || p == 2, p == 1, p < 4};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL round_robin c%0d got %b exp %b", c, got, exp); end
      if (c == 25) req_i = '0;
    end
    do_reset();
    req_i = 4'b1010;
    ycnt_i = 8'b01010101;
    @(negedge clk);
    n_chk++;
    if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL rr_sparse_first got %b exp 0010", gnt_o); end
    repeat (5) @(negedge clk);
    n_chk++;
    if (gnt_o !== 4'b1000 || x_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_sparse_second got gnt %b x %b exp 1000 1", gnt_o, x_o);
    end
    req_i = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    req_i = 4'b0100;
    ycnt_i = 8'b00110000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp = (c == 1) ? {4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1} :
            (c <= 3) ? {4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1} :
            (c <= 5) ? 11'b0 : {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL abort c%0d got %b exp %b", c, got, exp); end
      req_i = (c == 5) ? 4'b0101 : 4'b0000;
      abort_i = (c == 3);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_i = 4'b0010;
    ycnt_i = '0;
    @(negedge clk);
    req_i = '0;
    repeat (3) @(negedge clk);
    req_i = 4'b1000;
    ycnt_i = 8'b11000000;
    @(negedge clk);
    req_i = '0;
    @(negedge clk);
    n_chk++;
    if (got !== {4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_pre got %b exp 10000000011", got);
    end
    #2 reset_n = 0;
    #1;
    n_chk++;
    if (got !== 11'b0) begin n_fail++; $display("FAIL reset_mid_async got %b exp %b", got, 11'b0); end
    repeat (2) @(negedge clk);
    reset_n = 1;
    req_i = 4'b0110;
    @(negedge clk);
    n_chk++;
    if (got !== {4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_regrant got %b exp 00100000101", got);
    end
    req_i = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_churn();
    int ny;
    ny = 0;
    req_i = 4'b0001;
    ycnt_i = 8'b00000010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      ny += int'(y_o);
      exp = {(c <= 5) ? 4'b0001 : 4'b0000, (c == 5) ? 4'b0001 : 4'b0000,
             c == 1 || c == 4, c == 2 || c == 3, c <= 5};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL churn c%0d got %b exp %b", c, got, exp); end
      if (c == 1) begin req_i = '0; ycnt_i = 8'hFF; end
    end
    n_chk++;
    if (ny != 2) begin n_fail++; $display("FAIL churn_ycount got %0d exp 2", ny); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0;
    reset_n = 1;
    req_i = '0;
    ycnt_i = '0;
    abort_i = 0;
    n_chk = 0;
    n_fail = 0;
    #1;
    test_reset();
    test_single();
    test_zero_count();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_churn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
